// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg
// Shared definitions for the receive bit timer:
//   rx_state_t        - timer FSM states IDLE / ALIGN / RUN
//   CLKS_PER_BIT_DEF  - default system clocks per serial bit
//   SAMPLE_PT_DEF     - default phase at which a bit is sampled
//   cnt_width()       - counter width needed to hold 0..n-1
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 8;
  localparam int SAMPLE_PT_DEF    = 3;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_sync_counter.sv
// rx_sync_counter
// Synchronous up-counter with clear, load and programmable rollover.
// Priority: i_rst > i_clear > i_load > i_en.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - synchronous active-high reset
//   i_clear     - synchronous clear to zero
//   i_en        - count enable
//   i_load      - load i_load_val
//   i_load_val  - value loaded when i_load is high
//   i_roll_val  - terminal count; the count after it is zero
//   i_roll_en   - enables i_roll_val; when low the counter wraps naturally
//   o_count     - current count
//   o_roll      - high in the cycle an enabled increment rolls over to zero
module rx_sync_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_roll_val,
  input  logic         i_roll_en,
  output logic [W-1:0] o_count,
  output logic         o_roll
);

  logic [W-1:0] r_count;
  logic         w_at_roll;

  assign w_at_roll = i_roll_en && (r_count == i_roll_val);
  // Rollover flag is suppressed whenever a higher-priority action wins.
  assign o_roll    = i_en && w_at_roll && !i_clear && !i_load && !i_rst;
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_load)  r_count <= i_load_val;
    else if (i_en)    r_count <= w_at_roll ? '0 : r_count + 1'b1;
  end

endmodule

// File: rtl/rx_timer.sv
// rx_timer
// Receive bit timer for a UART-style receiver. Waits in ALIGN for the
// first line transition, then runs a phase counter over CLKS_PER_BIT
// clocks and strobes the shift register at phase SAMPLE_PT. A second
// counter tracks bits in the current byte and flags byte completion.
// Optional feature macro: RX_TIMER_RESYNC_EN -- realign the phase on
// every line transition while running and flag transitions that land
// exactly on the sampling point.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   enable_timer  - receive in progress
//   d_edge        - single-cycle line transition pulse
//   clear         - synchronous clear of bit count
//   roll_val      - bits per byte (0 = never complete, free 4-bit wrap)
//   shift_strobe  - sample command to the shift register
//   byte_received - pulse on the strobe that completes a byte
//   bit_count     - bits sampled in the current byte
//   resync_err    - pulse when a transition coincides with the sample point
module rx_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_PT    = SAMPLE_PT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  input  logic       clear,
  input  logic [3:0] roll_val,
  output logic       shift_strobe,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       resync_err
);

  localparam int              PH_W      = cnt_width(CLKS_PER_BIT);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PT);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);

  rx_state_t       r_state;
  logic [PH_W-1:0] w_phase;
  logic            w_at_sample;
  logic            w_align_hit;
  logic            w_resync_load;
  logic            w_phase_clear;
  logic            w_bit_clear;
  logic [3:0]      w_roll_last;

  assign w_at_sample = (r_state == RUN) && (w_phase == PH_SAMPLE);
  assign w_align_hit = (r_state == ALIGN) && d_edge && enable_timer;
  assign shift_strobe = w_at_sample && !rst;

`ifdef RX_TIMER_RESYNC_EN
  // An edge on the sampling point is ambiguous about which bit it
  // belongs to, so it is reported instead of used to realign; the
  // phase keeps running and the next strobe stays a full bit away.
  assign w_resync_load = (r_state == RUN) && d_edge && !w_at_sample;
  assign resync_err    = shift_strobe && d_edge;
`else
  assign w_resync_load = 1'b0;
  assign resync_err    = 1'b0;
`endif

  // Phase holds at zero outside RUN; the aligning edge counts as phase 0.
  assign w_phase_clear = !enable_timer || (r_state == IDLE);
  assign w_bit_clear   = clear || !enable_timer || (r_state != RUN);
  assign w_roll_last   = roll_val - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (!enable_timer) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    r_state <= ALIGN;
        ALIGN:   if (d_edge) r_state <= RUN;
        RUN:     r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end

  rx_sync_counter #(.W(PH_W)) u_phase (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_phase_clear),
    .i_en       (r_state == RUN),
    .i_load     (w_align_hit || w_resync_load),
    .i_load_val (PH_ONE),
    .i_roll_val (PH_LAST),
    .i_roll_en  (1'b1),
    .o_count    (w_phase),
    .o_roll     ()
  );

  // roll_val is used live on each strobe; zero disables byte completion.
  rx_sync_counter #(.W(4)) u_bits (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_bit_clear),
    .i_en       (shift_strobe),
    .i_load     (1'b0),
    .i_load_val (4'd0),
    .i_roll_val (w_roll_last),
    .i_roll_en  (roll_val != 4'd0),
    .o_count    (bit_count),
    .o_roll     (byte_received)
  );

endmodule

// File: tb/tb_rx_timer.sv
module tb_rx_timer;
  import rx_timer_pkg::*;

`ifdef RX_TIMER_RESYNC_EN
  localparam int RES = 1;
`else
  localparam int RES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_timer;
  logic       d_edge;
  logic       clear;
  logic [3:0] roll_val;
  logic       shift_strobe;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       resync_err;

  rx_timer #(.CLKS_PER_BIT(8), .SAMPLE_PT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_timer  (enable_timer),
    .d_edge        (d_edge),
    .clear         (clear),
    .roll_val      (roll_val),
    .shift_strobe  (shift_strobe),
    .byte_received (byte_received),
    .bit_count     (bit_count),
    .resync_err    (resync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int bc;
    int br;
    int re;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int bc, input int br, input int re);
    exp_t e;
    e.c = c; e.bc = bc; e.br = br; e.re = re;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (shift_strobe) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe_cycle", cyc, -1);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", cyc, e.c);
          chk("bit_count_at_strobe", int'(bit_count), e.bc);
          chk("byte_received", int'(byte_received), e.br);
          chk("resync_err", int'(resync_err), e.re);
        end
      end else begin
        if (byte_received) chk("byte_without_strobe", 1, 0);
        if (resync_err)    chk("resync_without_strobe", 1, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_byte(output int e);
    enable_timer = 1'b1;
    repeat (5) tick();
    d_edge = 1'b1;
    e = cyc;
    tick();
    d_edge = 1'b0;
  endtask

  task automatic stop_rx();
    enable_timer = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int e, e2, s1, s2, s3;
    rst = 1'b1; enable_timer = 1'b1; d_edge = 1'b1; clear = 1'b0; roll_val = 4'd8;

    // Reset held two cycles with enable and edge active
    tick();
    @(negedge clk);
    chk("rst_strobe", int'(shift_strobe), 0);
    chk("rst_byte", int'(byte_received), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    chk("rst_resync", int'(resync_err), 0);
    tick();
    rst = 1'b0; d_edge = 1'b0;
    @(negedge clk);
    chk("state_after_release", int'(dut.r_state), int'(IDLE));
    chk("bit_count_after_release", int'(bit_count), 0);
    tick();
    @(negedge clk);
    chk("state_align", int'(dut.r_state), int'(ALIGN));
    stop_rx();

    // Nominal byte
    start_byte(e);
    for (int i = 0; i < 8; i++) push(e + 3 + 8*i, i, (i == 7) ? 1 : 0, 0);
    goto(e + 20);
    @(negedge clk);
    chk("bit_count_mid", int'(bit_count), 3);
    goto(e + 60);
    @(negedge clk);
    chk("bit_count_after_byte", int'(bit_count), 0);
    tick();
    stop_rx();
    @(negedge clk);
    chk("state_idle_after_stop", int'(dut.r_state), int'(IDLE));

    // Late edge, then edge on the sample point
    start_byte(e);
    push(e + 3, 0, 0, 0);
    goto(e + 6);
    d_edge = 1'b1; tick(); d_edge = 1'b0;
    s1 = (RES == 1) ? e + 9 : e + 11;
    s2 = s1 + 8;
    s3 = s2 + 8;
    push(s1, 1, 0, 0);
    push(s2, 2, 0, RES);
    push(s3, 3, 0, 0);
    goto(s2);
    d_edge = 1'b1; tick(); d_edge = 1'b0;
    goto(s3 + 2);
    stop_rx();

    // Clear coincident with the 8th strobe
    start_byte(e);
    for (int i = 0; i < 8; i++) push(e + 3 + 8*i, i, 0, 0);
    push(e + 67, 0, 0, 0);
    goto(e + 59);
    clear = 1'b1; tick(); clear = 1'b0;
    @(negedge clk);
    chk("bit_count_after_clear", int'(bit_count), 0);
    goto(e + 69);
    stop_rx();

    // Enable dropped after 5 bits
    start_byte(e);
    for (int i = 0; i < 5; i++) push(e + 3 + 8*i, i, 0, 0);
    goto(e + 37);
    enable_timer = 1'b0;
    tick();
    @(negedge clk);
    chk("state_idle_after_drop", int'(dut.r_state), int'(IDLE));
    chk("bit_count_after_drop", int'(bit_count), 0);
    repeat (10) tick();
    enable_timer = 1'b1;
    repeat (15) tick();
    @(negedge clk);
    chk("state_align_no_edge", int'(dut.r_state), int'(ALIGN));
    tick();
    d_edge = 1'b1; e2 = cyc; tick(); d_edge = 1'b0;
    push(e2 + 3, 0, 0, 0);
    goto(e2 + 5);
    stop_rx();

    // roll_val = 0 wraps 15 -> 0 with no byte; then roll_val changed live to 3
    roll_val = 4'd0;
    start_byte(e);
    for (int i = 0; i < 17; i++) push(e + 3 + 8*i, i % 16, 0, 0);
    goto(e + 132);
    roll_val = 4'd3;
    push(e + 139, 1, 0, 0);
    push(e + 147, 2, 1, 0);
    push(e + 155, 0, 0, 0);
    goto(e + 157);
    stop_rx();
    roll_val = 4'd8;

    // Reset mid-byte discards the partial count
    start_byte(e);
    for (int i = 0; i < 3; i++) push(e + 3 + 8*i, i, 0, 0);
    goto(e + 22);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("bit_count_after_midrst", int'(bit_count), 0);
    chk("byte_after_midrst", int'(byte_received), 0);
    chk("state_after_midrst", int'(dut.r_state), int'(IDLE));
    repeat (12) tick();
    stop_rx();

    repeat (5) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_timer.md
RX_TIMER -- requirements
Module: rx_timer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning system clocks per serial bit period.
REQ-002 SHALL have parameter SAMPLE_PT, default 3, meaning phase value (0..CLKS_PER_BIT-1) at which a bit is sampled.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable_timer  input  1  receive-in-progress qualifier from receiver control unit.
REQ-006 SHALL have port d_edge  input  1  single-cycle pulse marking a line transition, from edge detector.
REQ-007 SHALL have port clear  input  1  synchronous clear of bit count.
REQ-008 SHALL have port roll_val  input  4  bits per byte window (normally 8).
REQ-009 SHALL have port shift_strobe  output  1  one-cycle pulse commanding the shift register to sample.
REQ-010 SHALL have port byte_received  output  1  one-cycle pulse on the strobe completing a byte.
REQ-011 SHALL have port bit_count  output  4  bits sampled in the current byte.
REQ-012 SHALL have port resync_err  output  1  one-cycle pulse on an edge at the sampling point.

Function
REQ-013 SHALL implement states IDLE, ALIGN, RUN.
REQ-014 SHALL transition: IDLE->ALIGN when enable_timer=1; ALIGN->RUN on d_edge; any state->IDLE in the cycle after enable_timer=0.
REQ-015 SHALL, in IDLE and ALIGN, hold phase=0 and bit_count=0, with all pulse outputs 0.
REQ-016 SHALL treat the d_edge cycle in ALIGN as phase 0, loading phase=1 on entry to RUN.
REQ-017 SHALL, in RUN, increment phase each cycle and wrap CLKS_PER_BIT-1 -> 0.
REQ-018 SHALL assert shift_strobe combinationally when state=RUN and registered phase==SAMPLE_PT, giving latency SAMPLE_PT cycles from the aligning edge.
REQ-019 SHALL increment bit_count on each shift_strobe; on the strobe where bit_count==roll_val-1, SHALL assert byte_received in that cycle and load bit_count=0.
REQ-020 SHALL, with roll_val=0, never assert byte_received and wrap bit_count 15->0.
REQ-021 SHALL give clear priority over increment: bit_count<=0 and byte_received suppressed, while shift_strobe and phase are unaffected.
REQ-022 SHALL, when d_edge and phase==SAMPLE_PT coincide in RUN, still issue shift_strobe in that cycle.
REQ-023 SHALL sample roll_val on every strobe, not latch it.

Reset
REQ-024 SHALL on rst=1 force state=IDLE, phase=0, bit_count=0, shift_strobe=0, byte_received=0, resync_err=0, with priority over all other inputs.
REQ-025 SHALL on rst mid-byte discard partial count, with no byte_received on the cycle after reset.

Configuration
REQ-026 SHALL honour macro RX_TIMER_RESYNC_EN.
REQ-027 SHALL, when the macro is defined, treat d_edge in RUN as realignment: phase<=1, bit_count unchanged; resync_err pulses if phase==SAMPLE_PT at that edge.
REQ-028 SHALL, when the macro is undefined, ignore d_edge in RUN (free-running phase) and tie resync_err to 0.

Structure
REQ-029 SHALL place the state enum (IDLE/ALIGN/RUN) and default constants CLKS_PER_BIT_DEF=8, SAMPLE_PT_DEF=3 in package rx_timer_pkg.
REQ-030 SHALL implement phase and bit counters as two instances of sub-module rx_sync_counter (sync active-high reset, clear, enable, load, rollover value, rollover flag).

Verification (CLKS_PER_BIT=8, SAMPLE_PT=3, roll_val=8)
REQ-031 SHALL cover reset: rst held 2 cycles with enable_timer=1, d_edge=1 -> all outputs 0, state IDLE after release.
REQ-032 SHALL cover nominal byte: enable at cycle 5, d_edge at cycle 10 -> shift_strobe at cycles 13,21,...,69, with byte_received and bit_count 7->0 at cycle 69.
REQ-033 SHALL cover late resync (macro on): d_edge at phase 6 -> next strobe exactly 3 cycles after the edge, with resync_err=0.
REQ-034 SHALL cover edge on sample point (macro on): d_edge at phase 3 -> strobe that cycle, resync_err=1 for one cycle, next strobe 8 cycles later; macro off -> resync_err=0, with strobe spacing unchanged.
REQ-035 SHALL cover clear coincident with the 8th strobe -> shift_strobe=1, byte_received=0, bit_count=0.
REQ-036 SHALL cover enable_timer dropped after 5 bits -> IDLE next cycle, bit_count=0, with no further strobes until ALIGN plus a new d_edge.
